// File: rtl/cpu_pkg.sv
// Shared datapath definitions: word width, divider FSM states and the
// quotient value reported for a divide by zero.
package cpu_pkg;

    localparam int WORD_WIDTH = 32;

    // Quotient written to LO when the divisor is zero.
    localparam logic [WORD_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// The partial remainder is WIDTH+1 bits so the trial subtraction's sign
// is visible. A set top bit on the incoming remainder means the shifted
// value already exceeds any WIDTH-bit divisor, so the subtraction is kept.
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           keep;

    // Shift {remainder, quotient} left, trial-subtract, restore on borrow.
    always_comb begin
        shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        keep    = rem_in[WIDTH] | ~trial[WIDTH];
        rem_out = keep ? trial : shifted;
        quo_out = {quo_in[WIDTH-2:0], keep};
    end

endmodule

// File: rtl/div_unit.sv
// Sequential radix-2 restoring divider for the DIV instruction.
// LO = quotient, HI = remainder, held until the next completion.
// Optional build macro: DIV_SIGNED_EN selects two's-complement signed
// (truncating) division; undefined gives unsigned division.
//
// Handshake: start is sampled only while IDLE. The accepting edge
// captures dividend/divisor; start while busy is dropped, not queued.
// done pulses for one cycle on the edge results update, and the FSM is
// IDLE in that cycle, so a start held there is accepted back-to-back.
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             div_by_zero,
    output div_state_t       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic             dz_pend;

    logic [WIDTH-1:0] op_dvd;
    logic [WIDTH-1:0] op_dvs;
    logic [WIDTH-1:0] fix_lo;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    assign state_dbg = state;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Operand magnitudes; 0x80000000 maps to itself, read as unsigned 2^31.
    assign op_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    assign op_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;
    // Quotient negated on differing signs, remainder follows the dividend.
    assign fix_lo = neg_q ? -quo : quo;
    assign fix_hi = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
`else
    assign op_dvd = dividend;
    assign op_dvs = divisor;
    assign fix_lo = quo;
    assign fix_hi = rem[WIDTH-1:0];
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .dvs     (dvs_mag),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Control FSM, iteration counter, working registers and result registers.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs_mag     <= '0;
            dz_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lo_out      <= '0;
            hi_out      <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            // Zero divisor: stage the fixed results and skip CALC.
                            rem     <= {1'b0, dividend};
                            quo     <= DIV_ZERO_QUOTIENT;
                            dz_pend <= 1'b1;
                            state   <= FIX;
`ifdef DIV_SIGNED_EN
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
`endif
                        end else begin
                            rem     <= '0;
                            quo     <= op_dvd;
                            dvs_mag <= op_dvs;
                            dz_pend <= 1'b0;
                            count   <= CW'(WIDTH - 1);
                            state   <= CALC;
`ifdef DIV_SIGNED_EN
                            neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_r   <= dividend[WIDTH-1];
`endif
                        end
                    end
                end
                CALC: begin
                    rem   <= step_rem;
                    quo   <= step_quo;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo_out      <= fix_lo;
                    hi_out      <= fix_hi;
                    div_by_zero <= dz_pend;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed test-plan cases, random
// operations against an arithmetic reference, start-while-busy, back-to-back
// and mid-operation reset. Build with DIV_SIGNED_EN to check the signed build.
module tb_div_unit;
    import cpu_pkg::*;

    localparam int W = WORD_WIDTH;

    logic         clock = 1'b0;
    logic         clear_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] lo_out;
    logic [W-1:0] hi_out;
    logic         div_by_zero;
    div_state_t   state_dbg;

    int n_checks = 0;
    int n_fail = 0;

    // Expected {div_by_zero, hi, lo} per accepted operation, in order.
    logic [2*W:0] exp_q[$];

    div_unit dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .lo_out      (lo_out),
        .hi_out      (hi_out),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // Clock / reset
    always #5 clock = ~clock;

    // Reference: plain integer division on 64-bit values.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == '0) return {1'b1, a, {W{1'b1}}};
`ifdef DIV_SIGNED_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'({{(64-W){1'b0}}, a});
        sb = longint'({{(64-W){1'b0}}, b});
`endif
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    // Driver + scoreboard: run one operation, leave time at the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic [2*W:0] exp;
        int lat;
        int busy_cycles;
        int exp_lat;
        exp_lat = (b == '0) ? 1 : W + 1;
        exp_q.push_back(model(a, b));
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            @(posedge clock);
            #1;
            lat++;
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (busy_cycles !== exp_lat) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cycles, exp_lat);
        end
        n_checks++;
        if (lo_out !== exp[W-1:0]) begin
            n_fail++;
            $display("FAIL %s lo: got %h, expected %h", name, lo_out, exp[W-1:0]);
        end
        n_checks++;
        if (hi_out !== exp[2*W-1:W]) begin
            n_fail++;
            $display("FAIL %s hi: got %h, expected %h", name, hi_out, exp[2*W-1:W]);
        end
        n_checks++;
        if (div_by_zero !== exp[2*W] || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dz/busy: got %b/%b, expected %b/0", name, div_by_zero, busy, exp[2*W]);
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || lo_out !== '0 || hi_out !== '0 ||
            div_by_zero !== 1'b0 || state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b lo=%h hi=%h dz=%b st=%0d, expected all 0 / IDLE",
                     busy, done, lo_out, hi_out, div_by_zero, state_dbg);
        end
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b done=%b st=%0d, expected 0/0/IDLE",
                     busy, done, state_dbg);
        end
    endtask

    task automatic test_directed();
        run_op(32'd100, 32'd7, "100/7");
        n_checks++;
        if (lo_out !== 32'd14 || hi_out !== 32'd2) begin
            n_fail++;
            $display("FAIL 100/7 const: got lo=%0d hi=%0d, expected 14/2", lo_out, hi_out);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_width: got done=%b one cycle later, expected 0", done);
        end
        run_op(32'd1234, 32'd0, "1234/0");
        n_checks++;
        if (lo_out !== 32'hFFFF_FFFF || hi_out !== 32'd1234 || div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL div0 const: got lo=%h hi=%0d dz=%b, expected ffffffff/1234/1",
                     lo_out, hi_out, div_by_zero);
        end
        run_op(32'd9, 32'd3, "9/3");
        n_checks++;
        if (lo_out !== 32'd3 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL 9/3 const: got lo=%0d dz=%b, expected 3/0", lo_out, div_by_zero);
        end
`ifdef DIV_SIGNED_EN
        run_op(-32'sd100, 32'd7, "-100/7");
        n_checks++;
        if (lo_out !== 32'hFFFF_FFF2 || hi_out !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL -100/7 const: got %h/%h, expected fffffff2/fffffffe", lo_out, hi_out);
        end
        run_op(32'd100, -32'sd7, "100/-7");
        n_checks++;
        if (lo_out !== 32'hFFFF_FFF2 || hi_out !== 32'd2) begin
            n_fail++;
            $display("FAIL 100/-7 const: got %h/%h, expected fffffff2/00000002", lo_out, hi_out);
        end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, "min/-1");
        n_checks++;
        if (lo_out !== 32'h8000_0000 || hi_out !== 32'd0) begin
            n_fail++;
            $display("FAIL min/-1 const: got %h/%h, expected 80000000/00000000", lo_out, hi_out);
        end
        run_op(32'hFFFF_FFF9, 32'd0, "-7/0");
`else
        run_op(32'hFFFF_FFFF, 32'd2, "max/2");
        n_checks++;
        if (lo_out !== 32'h7FFF_FFFF || hi_out !== 32'd1) begin
            n_fail++;
            $display("FAIL max/2 const: got %h/%h, expected 7fffffff/00000001", lo_out, hi_out);
        end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, "big/max");
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                3:       b = $urandom | 32'h8000_0000;
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1000)) : $urandom;
            run_op(a, b, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_start_while_busy();
        logic [2*W:0] exp;
        logic [W-1:0] lo_prev;
        logic [W-1:0] hi_prev;
        int lat;
        int stable_err;
        exp_q.push_back(model(32'd100, 32'd7));
        lo_prev = lo_out;
        hi_prev = hi_out;
        @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat = 0;
        stable_err = 0;
        while (!done && lat < 100) begin
            // Drive a start to be sampled at edges 5 and 20.
            start = (lat == 4 || lat == 19);
            dividend = $urandom;
            divisor  = (lat == 19) ? '0 : W'($urandom_range(1, 5));
            @(posedge clock);
            #1;
            lat++;
            if (!done && (lo_out !== lo_prev || hi_out !== hi_prev)) stable_err++;
        end
        start = 1'b0;
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== W + 1) begin
            n_fail++;
            $display("FAIL busy_start latency: got %0d, expected %0d", lat, W + 1);
        end
        n_checks++;
        if (stable_err !== 0) begin
            n_fail++;
            $display("FAIL busy_start outputs_held: got %0d early changes, expected 0", stable_err);
        end
        n_checks++;
        if (lo_out !== exp[W-1:0] || hi_out !== exp[2*W-1:W] || div_by_zero !== exp[2*W]) begin
            n_fail++;
            $display("FAIL busy_start result: got %h/%h/%b, expected %h/%h/%b",
                     lo_out, hi_out, div_by_zero, exp[W-1:0], exp[2*W-1:W], exp[2*W]);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start no_requeue: got done=%b busy=%b, expected 0/0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W:0] exp;
        int lat;
        run_op(32'd5000, 32'd13, "b2b_first");
        // Now in the done cycle: hold start for the next edge.
        exp_q.push_back(model(32'd77777, 32'd123));
        dividend = 32'd77777;
        divisor  = 32'd123;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== W + 1) begin
            n_fail++;
            $display("FAIL b2b latency: got %0d, expected %0d", lat, W + 1);
        end
        n_checks++;
        if (lo_out !== exp[W-1:0] || hi_out !== exp[2*W-1:W]) begin
            n_fail++;
            $display("FAIL b2b result: got %h/%h, expected %h/%h",
                     lo_out, hi_out, exp[W-1:0], exp[2*W-1:W]);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen_done;
        run_op(32'd100, 32'd7, "pre_reset");
        @(negedge clock);
        dividend = 32'd55;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
        end
        #1;
        clear_n = 1'b0;
        #1;
        n_checks++;
        if (lo_out !== '0 || hi_out !== '0 || div_by_zero !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL midop_reset: got lo=%h hi=%h dz=%b busy=%b done=%b st=%0d, expected 0 / IDLE",
                     lo_out, hi_out, div_by_zero, busy, done, state_dbg);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL midop_abandon: got %0d done pulses, expected 0", seen_done);
        end
        run_op(32'd81, 32'd9, "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
